mem_rle_scanner: RTL

Parametrised memory scanner that walks a contiguous, wrapping address window of a single-port SRAM (CPU_MEM-style: active-low chip/write selects, one-cycle read latency). It compresses the words into run-length tokens of (value, repeat count) and emits them on a single valid/ready stream. It supersedes the fixed 8-bit, whole-memory reader: data, address and count widths are configurable, the window is programmable, the mode is selectable, run counts saturate, and data and repeat count travel as one token.

---
 rtl/mem_rle_pkg.sv | 15 +
 rtl/mem_rle_run.sv | 46 ++++
 rtl/mem_rle_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_rle_pkg.sv
// Shared types for the run-length memory scanner.
package mem_rle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        EMIT,
        LAST
    } state_t;

    localparam logic MODE_RAW = 1'b0;
    localparam logic MODE_RLE = 1'b1;

endpackage

// File: rtl/mem_rle_run.sv
// Open-run tracker: holds the current (value, count) pair and decides
// whether a freshly read word extends it or starts a new run.
module mem_rle_run
    import mem_rle_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic              mode,
    output logic              match_extend,
    output logic              run_open,
    output logic [DATA_W-1:0] run_val,
    output logic [CNT_W-1:0]  run_cnt,
    output logic [DATA_W-1:0] next_val,
    output logic [CNT_W-1:0]  next_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A word extends the run only in RLE mode, on equal value, below saturation.
    assign match_extend = run_open && (mode == MODE_RLE) && (d == run_val) && (run_cnt != CNT_MAX);
    assign next_val     = match_extend ? run_val : d;
    assign next_cnt     = match_extend ? (run_cnt + CNT_ONE) : CNT_ONE;

    // Run register: cleared at job start, updated on every captured word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_open <= 1'b0;
            run_val  <= '0;
            run_cnt  <= '0;
        end else if (clear) begin
            run_open <= 1'b0;
        end else if (load) begin
            run_open <= 1'b1;
            run_val  <= next_val;
            run_cnt  <= next_cnt;
        end
    end

endmodule

// File: rtl/mem_rle_scanner.sv
// Walks a wrapping SRAM address window and emits (value, count) tokens
// on a valid/ready stream, either raw or run-length compressed.
module mem_rle_scanner
    import mem_rle_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t              state;
    logic                mode_r;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     rem;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W:0]     rem_dec;
    logic                run_clear;
    logic                run_load;
    logic                match_extend;
    logic                run_open;
    logic [DATA_W-1:0]   run_val;
    logic [CNT_W-1:0]    run_cnt;
    logic [DATA_W-1:0]   next_val;
    logic [CNT_W-1:0]    next_cnt;

    assign web0      = 1'b1;
    assign addr_inc  = addr + ADDR_W'(1);
    assign rem_dec   = rem - {{ADDR_W{1'b0}}, 1'b1};
    assign run_clear = (state == IDLE) && start && (length != '0);
    assign run_load  = (state == CAP);

    mem_rle_run #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_run (
        .clk          (clk),
        .reset        (reset),
        .clear        (run_clear),
        .load         (run_load),
        .d            (dout0),
        .mode         (mode_r),
        .match_extend (match_extend),
        .run_open     (run_open),
        .run_val      (run_val),
        .run_cnt      (run_cnt),
        .next_val     (next_val),
        .next_cnt     (next_cnt)
    );

    // Sequencer: all SRAM and stream outputs are registered here.
    // Entering LAST straight from CAP loads the run's next value, since
    // the run register updates on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_r    <= MODE_RAW;
            addr      <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            csb0      <= 1'b1;
            addr0     <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            mode_r <= mode;
                            addr   <= base_addr;
                            addr0  <= base_addr;
                            rem    <= length;
                            csb0   <= 1'b0;
                            busy   <= 1'b1;
                            state  <= REQ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    csb0  <= 1'b1;
                    state <= CAP;
                end
                CAP: begin
                    addr <= addr_inc;
                    rem  <= rem_dec;
                    if (run_open && !match_extend) begin
                        out_data  <= run_val;
                        out_count <= run_cnt;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (rem_dec != '0) begin
                        addr0 <= addr_inc;
                        csb0  <= 1'b0;
                        state <= REQ;
                    end else begin
                        out_data  <= next_val;
                        out_count <= next_cnt;
                        out_valid <= 1'b1;
                        state     <= LAST;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (rem != '0) begin
                            out_valid <= 1'b0;
                            addr0     <= addr;
                            csb0      <= 1'b0;
                            state     <= REQ;
                        end else begin
                            out_data  <= run_val;
                            out_count <= run_cnt;
                            state     <= LAST;
                        end
                    end
                end
                LAST: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
